// File: rtl/eaglesong_pkg.sv
// Shared types and constants for the Eaglesong nonce search front end.
package eaglesong_pkg;

   // Message fed to the digest core is always 32 bytes: header followed by nonce.
   localparam int EAGLESONG_MSG_BYTES = 32;
   localparam int EAGLESONG_DIGEST_W  = 256;

   // Job controller states.
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LAUNCH,
      ST_WAIT,
      ST_CHECK,
      ST_DONE,
      ST_ERROR
   } search_state_t;

   // True when a digest satisfies the target (unsigned, inclusive).
   function automatic logic digest_meets_target(
      input logic [EAGLESONG_DIGEST_W-1:0] digest,
      input logic [EAGLESONG_DIGEST_W-1:0] target
   );
      return (digest <= target);
   endfunction

endpackage

// File: rtl/eaglesong_nonce_search.sv
// Eaglesong nonce search job controller.
// Accepts a job (header, target, nonce range), drives eaglesong_digest_top one
// nonce at a time and reports the first nonce whose digest is <= target, or
// the next untried nonce once the range is exhausted. The result is held
// until res_ack.
// Optional build macro EAGLESONG_SEARCH_STATS_EN adds stat_hashes, a
// saturating count of completed digest checks since reset.
module eaglesong_nonce_search
   import eaglesong_pkg::*;
#(
   parameter int NONCE_W      = 64,
   parameter int HEADER_BYTES = 24,
   parameter int TIMEOUT_CYC  = 4096
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          job_valid,
   output logic                          job_ready,
   input  logic [8*HEADER_BYTES-1:0]     job_header,
   input  logic [EAGLESONG_DIGEST_W-1:0] job_target,
   input  logic [NONCE_W-1:0]            job_nonce_start,
   input  logic [NONCE_W-1:0]            job_nonce_count,
   input  logic                          abort,
   output logic [EAGLESONG_DIGEST_W-1:0] digest_input,
   output logic [6:0]                    digest_len,
   output logic                          digest_start,
   input  logic [EAGLESONG_DIGEST_W-1:0] digest_val,
   input  logic                          digest_ready,
   output logic                          res_valid,
   input  logic                          res_ack,
   output logic                          res_found,
   output logic [NONCE_W-1:0]            res_nonce,
   output logic [EAGLESONG_DIGEST_W-1:0] res_digest,
   output logic                          err_timeout
`ifdef EAGLESONG_SEARCH_STATS_EN
   ,
   output logic [31:0]                   stat_hashes
`endif
);

   localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

   // Reject geometries where header + nonce do not fill the 32-byte message.
   generate
      if ((NONCE_W % 8) != 0 || NONCE_W > 128 ||
          HEADER_BYTES != EAGLESONG_MSG_BYTES - NONCE_W / 8) begin : g_bad_cfg
         $error("eaglesong_nonce_search: HEADER_BYTES must equal 32 - NONCE_W/8 with NONCE_W a multiple of 8 and <= 128");
      end
   endgenerate

   search_state_t                 state_reg, state_next;
   logic [8*HEADER_BYTES-1:0]     header_reg;
   logic [EAGLESONG_DIGEST_W-1:0] target_reg;
   logic [NONCE_W-1:0]            cur_nonce_reg;
   logic [NONCE_W-1:0]            remaining_reg;
   logic [TMR_W-1:0]              timer_reg;
   logic [EAGLESONG_DIGEST_W-1:0] digest_cap_reg;
   logic [EAGLESONG_DIGEST_W-1:0] digest_input_reg;
   logic                          digest_start_reg;
   logic                          res_found_reg;
   logic [NONCE_W-1:0]            res_nonce_reg;
   logic [EAGLESONG_DIGEST_W-1:0] res_digest_reg;
   logic                          err_timeout_reg;

   logic                          job_accept;
   logic                          count_zero;
   logic                          blanking;
   logic                          timer_expired;
   logic                          hit;
   logic                          last_try;
   logic [EAGLESONG_DIGEST_W-1:0] launch_msg;

   assign job_ready     = (state_reg == ST_IDLE) || (state_reg == ST_ERROR);
   assign job_accept    = job_valid && job_ready;
   assign count_zero    = (job_nonce_count == '0);
   // The digest core drops a stale ready only one cycle after start, so the
   // first WAIT cycle (timer still 0) must not look at digest_ready.
   assign blanking      = (timer_reg == '0);
   assign timer_expired = (timer_reg == TMR_W'(TIMEOUT_CYC));
   assign hit           = digest_meets_target(digest_cap_reg, target_reg);
   assign last_try      = (remaining_reg == NONCE_W'(1));

   // Message assembly: low bytes carry the header, upper bytes the nonce LSB first.
   generate
      for (genvar gi = 0; gi < EAGLESONG_MSG_BYTES; gi++) begin : g_msg
         if (gi < HEADER_BYTES) begin : g_hdr
            assign launch_msg[8*gi +: 8] = header_reg[8*gi +: 8];
         end else begin : g_nonce
            assign launch_msg[8*gi +: 8] = cur_nonce_reg[8*(gi-HEADER_BYTES) +: 8];
         end
      end
   endgenerate

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic for the search sequence.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (job_accept) begin
               state_next = count_zero ? ST_DONE : ST_LAUNCH;
            end
         end
         ST_LAUNCH: begin
            state_next = abort ? ST_IDLE : ST_WAIT;
         end
         ST_WAIT: begin
            if (abort) begin
               state_next = ST_IDLE;
            end else if (!blanking && digest_ready) begin
               state_next = ST_CHECK;
            end else if (timer_expired) begin
               state_next = ST_ERROR;
            end
         end
         ST_CHECK: begin
            if (abort) begin
               state_next = ST_IDLE;
            end else if (hit || last_try) begin
               state_next = ST_DONE;
            end else begin
               state_next = ST_LAUNCH;
            end
         end
         ST_DONE: begin
            // abort has no effect here; only the consumer releases the result.
            if (res_ack) begin
               state_next = ST_IDLE;
            end
         end
         ST_ERROR: begin
            // A new job takes priority over abort and clears the error.
            if (job_accept) begin
               state_next = count_zero ? ST_DONE : ST_LAUNCH;
            end else if (abort) begin
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Job context, launch registers, wait timer and result capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         header_reg       <= '0;
         target_reg       <= '0;
         cur_nonce_reg    <= '0;
         remaining_reg    <= '0;
         timer_reg        <= '0;
         digest_cap_reg   <= '0;
         digest_input_reg <= '0;
         digest_start_reg <= 1'b0;
         res_found_reg    <= 1'b0;
         res_nonce_reg    <= '0;
         res_digest_reg   <= '0;
         err_timeout_reg  <= 1'b0;
      end else begin
         digest_start_reg <= 1'b0;
         case (state_reg)
            ST_IDLE, ST_ERROR: begin
               if (job_accept) begin
                  header_reg      <= job_header;
                  target_reg      <= job_target;
                  cur_nonce_reg   <= job_nonce_start;
                  remaining_reg   <= job_nonce_count;
                  err_timeout_reg <= 1'b0;
                  if (count_zero) begin
                     res_found_reg  <= 1'b0;
                     res_nonce_reg  <= job_nonce_start;
                     res_digest_reg <= '0;
                  end
               end
            end
            ST_LAUNCH: begin
               timer_reg <= '0;
               if (!abort) begin
                  digest_input_reg <= launch_msg;
                  digest_start_reg <= 1'b1;
               end
            end
            ST_WAIT: begin
               if (!timer_expired) begin
                  timer_reg <= timer_reg + TMR_W'(1);
               end
               if (state_next == ST_CHECK) begin
                  digest_cap_reg <= digest_val;
               end
               if (state_next == ST_ERROR) begin
                  err_timeout_reg <= 1'b1;
               end
            end
            ST_CHECK: begin
               if (state_next == ST_DONE) begin
                  if (hit) begin
                     res_found_reg  <= 1'b1;
                     res_nonce_reg  <= cur_nonce_reg;
                     res_digest_reg <= digest_cap_reg;
                  end else begin
                     res_found_reg  <= 1'b0;
                     res_nonce_reg  <= cur_nonce_reg + NONCE_W'(1);
                     res_digest_reg <= '0;
                  end
               end else if (state_next == ST_LAUNCH) begin
                  cur_nonce_reg <= cur_nonce_reg + NONCE_W'(1);
                  remaining_reg <= remaining_reg - NONCE_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

`ifdef EAGLESONG_SEARCH_STATS_EN
   logic [31:0] stat_hashes_reg;

   // Saturating count of CHECK cycles that ran to completion.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_hashes_reg <= '0;
      end else if (state_reg == ST_CHECK && !abort && stat_hashes_reg != 32'hFFFF_FFFF) begin
         stat_hashes_reg <= stat_hashes_reg + 32'd1;
      end
   end

   assign stat_hashes = stat_hashes_reg;
`endif

   assign digest_input = digest_input_reg;
   assign digest_len   = 7'(EAGLESONG_MSG_BYTES);
   assign digest_start = digest_start_reg;
   assign res_valid    = (state_reg == ST_DONE);
   assign res_found    = res_found_reg;
   assign res_nonce    = res_nonce_reg;
   assign res_digest   = res_digest_reg;
   assign err_timeout  = err_timeout_reg;

endmodule

// File: tb/tb_eaglesong_nonce_search.sv
// Bench for eaglesong_nonce_search with a behavioural digest stub.
module tb_eaglesong_nonce_search;

   localparam int TO = 20;

   logic         clk;
   logic         rst;
   logic         job_valid;
   logic         job_ready;
   logic [191:0] job_header;
   logic [255:0] job_target;
   logic [63:0]  job_nonce_start;
   logic [63:0]  job_nonce_count;
   logic         abort;
   logic [255:0] digest_input;
   logic [6:0]   digest_len;
   logic         digest_start;
   logic [255:0] digest_val;
   logic         digest_ready;
   logic         res_valid;
   logic         res_ack;
   logic         res_found;
   logic [63:0]  res_nonce;
   logic [255:0] res_digest;
   logic         err_timeout;
`ifdef EAGLESONG_SEARCH_STATS_EN
   logic [31:0]  stat_hashes;
`endif

   eaglesong_nonce_search #(
      .NONCE_W(64), .HEADER_BYTES(24), .TIMEOUT_CYC(TO)
   ) dut (
      .clk(clk), .rst(rst),
      .job_valid(job_valid), .job_ready(job_ready), .job_header(job_header),
      .job_target(job_target), .job_nonce_start(job_nonce_start),
      .job_nonce_count(job_nonce_count), .abort(abort),
      .digest_input(digest_input), .digest_len(digest_len), .digest_start(digest_start),
      .digest_val(digest_val), .digest_ready(digest_ready),
      .res_valid(res_valid), .res_ack(res_ack), .res_found(res_found),
      .res_nonce(res_nonce), .res_digest(res_digest), .err_timeout(err_timeout)
`ifdef EAGLESONG_SEARCH_STATS_EN
      , .stat_hashes(stat_hashes)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int ncyc  = 0;

   always @(posedge clk) ncyc <= ncyc + 1;

   // Reference digest: an arbitrary fixed mixing function that the stub core computes.
   function automatic logic [255:0] ref_digest(input logic [255:0] m);
      logic [255:0] x;
      x = m ^ 256'h5A5A_A5A5_0F0F_F0F0_3C3C_C3C3_9696_6969_1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
      x = x * 256'h9E37_79B9_7F4A_7C15_F39C_C060_5CED_C835;
      x = x ^ {x[122:0], x[255:123]};
      return x;
   endfunction

   // Digest core stub: ready drops one cycle after start, rises stub_lat cycles later.
   logic         stub_ready;
   logic         stub_busy;
   logic [255:0] stub_out;
   logic [255:0] stub_msg;
   int           stub_cnt;
   int           stub_lat;
   logic         stub_dead;

   always @(posedge clk) begin
      if (rst) begin
         stub_ready <= 1'b0;
         stub_busy  <= 1'b0;
         stub_cnt   <= 0;
         stub_out   <= '0;
         stub_msg   <= '0;
      end else if (digest_start) begin
         stub_ready <= 1'b0;
         stub_busy  <= 1'b1;
         stub_cnt   <= stub_lat;
         stub_msg   <= digest_input;
      end else if (stub_busy) begin
         if (stub_cnt <= 1) begin
            stub_busy <= 1'b0;
            if (!stub_dead) begin
               stub_ready <= 1'b1;
               stub_out   <= ref_digest(stub_msg);
            end
         end else begin
            stub_cnt <= stub_cnt - 1;
         end
      end
   end

   assign digest_ready = stub_ready;
   assign digest_val   = stub_out;

   // Launch monitor: every start pulse with its message and cycle stamp.
   logic [255:0] starts_q[$];
   int           start_cyc_q[$];

   always @(negedge clk) begin
      if (digest_start) begin
         starts_q.push_back(digest_input);
         start_cyc_q.push_back(ncyc);
      end
   end

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_job_ready"}, 256'(job_ready), 256'(1));
      chk({tag, "_start"}, 256'(digest_start), 256'(0));
      chk({tag, "_res_valid"}, 256'(res_valid), 256'(0));
      chk({tag, "_res_found"}, 256'(res_found), 256'(0));
      chk({tag, "_res_nonce"}, 256'(res_nonce), 256'(0));
      chk({tag, "_res_digest"}, res_digest, 256'(0));
      chk({tag, "_err"}, 256'(err_timeout), 256'(0));
      chk({tag, "_digest_input"}, digest_input, 256'(0));
      chk({tag, "_digest_len"}, 256'(digest_len), 256'(32));
   endtask

   // Search model: walk the range with plain arithmetic.
   task automatic model(input logic [191:0] h, input logic [255:0] t, input logic [63:0] st,
                        input logic [63:0] cnt, output logic f, output logic [63:0] n,
                        output logic [255:0] d, output int launches);
      logic [63:0] nn;
      f = 1'b0; d = '0; launches = 0; n = st + cnt;
      for (longint unsigned i = 0; i < cnt; i++) begin
         nn = st + 64'(i);
         launches++;
         if (ref_digest({nn, h}) <= t) begin
            f = 1'b1; n = nn; d = ref_digest({nn, h});
            break;
         end
      end
   endtask

   // Results gathered by do_job.
   logic         got_found;
   logic [63:0]  got_nonce;
   logic [255:0] got_digest;
   logic         got_timeout;
   logic         got_valid_after_ack;
   int           drive_cyc;

   task automatic drive_job(input logic [191:0] h, input logic [255:0] t,
                            input logic [63:0] st, input logic [63:0] cnt);
      int g;
      @(negedge clk);
      g = 0;
      while (!job_ready && g < 100) begin
         @(negedge clk);
         g++;
      end
      starts_q.delete();
      start_cyc_q.delete();
      job_header = h; job_target = t; job_nonce_start = st; job_nonce_count = cnt;
      job_valid = 1'b1;
      drive_cyc = ncyc;
      @(negedge clk);
      job_valid = 1'b0;
   endtask

   task automatic do_job(input logic [191:0] h, input logic [255:0] t,
                         input logic [63:0] st, input logic [63:0] cnt, input int lat);
      int g;
      stub_lat = lat;
      drive_job(h, t, st, cnt);
      g = 0;
      while (!res_valid && g < 3000) begin
         @(negedge clk);
         g++;
      end
      got_timeout = !res_valid;
      got_found = res_found; got_nonce = res_nonce; got_digest = res_digest;
      res_ack = 1'b1;
      @(negedge clk);
      res_ack = 1'b0;
      got_valid_after_ack = res_valid;
   endtask

   // Checks shared by every completed job: wait bound, launched messages, latency, ack.
   task automatic check_common(input string tag, input logic [191:0] h,
                               input logic [63:0] st, input int exp_launch);
      logic seq_ok;
      int   lat;
      chk({tag, "_res_wait"}, 256'(got_timeout), 256'(0));
      chk({tag, "_launches"}, 256'(starts_q.size()), 256'(exp_launch));
      seq_ok = (starts_q.size() == exp_launch);
      foreach (starts_q[i]) begin
         if (starts_q[i] !== {st + 64'(i), h}) seq_ok = 1'b0;
      end
      chk({tag, "_msg_seq"}, 256'(seq_ok), 256'(1));
      if (exp_launch > 0) begin
         lat = (start_cyc_q.size() > 0) ? start_cyc_q[0] - drive_cyc : -1;
         chk({tag, "_launch_lat"}, 256'(lat), 256'(2));
      end
      chk({tag, "_ack_clears"}, 256'(got_valid_after_ack), 256'(0));
   endtask

   task automatic check_result(input string tag, input logic ef, input logic [63:0] en,
                               input logic [255:0] ed);
      chk({tag, "_found"}, 256'(got_found), 256'(ef));
      chk({tag, "_nonce"}, 256'(got_nonce), 256'(en));
      chk({tag, "_digest"}, got_digest, ed);
   endtask

   task automatic wait_start(output int s);
      int g;
      g = 0;
      while (!digest_start && g < 100) begin
         @(negedge clk);
         g++;
      end
      chk("wait_start", 256'(digest_start), 256'(1));
      s = ncyc;
   endtask

   typedef struct {
      logic [191:0] hdr;
      logic [255:0] tgt;
      logic [63:0]  start;
      logic [63:0]  cnt;
      logic         exp_found;
      logic [63:0]  exp_nonce;
      int           exp_launch;
   } vec_t;

   vec_t vecs[4];

   initial begin
      logic [191:0] h;
      logic [255:0] t, ed;
      logic [63:0]  st, cnt, en;
      logic         ef;
      int           el, s, e, g, n0;
      logic         saw_valid;

      vecs[0] = '{192'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_0011_2233_4455_6677, '1,
                  64'd5, 64'd10, 1'b1, 64'd5, 1};
      vecs[1] = '{192'hDEAD_BEEF_CAFE_F00D_1357_9BDF_2468_ACE0_AAAA_5555_0000_FFFF, '0,
                  64'd100, 64'd3, 1'b0, 64'd103, 3};
      vecs[2] = '{192'h1111_2222_3333_4444_5555_6666_7777_8888_9999_AAAA_BBBB_CCCC, '0,
                  64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, 64'd1, 2};
      vecs[3] = '{192'h0F0F_0F0F_F0F0_F0F0_0F0F_0F0F_F0F0_F0F0_0F0F_0F0F_F0F0_F0F0, '1,
                  64'd77, 64'd0, 1'b0, 64'd77, 0};

      rst = 1'b1; job_valid = 1'b0; abort = 1'b0; res_ack = 1'b0;
      job_header = '0; job_target = '0; job_nonce_start = '0; job_nonce_count = '0;
      stub_lat = 2; stub_dead = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check_reset_outputs("reset");

      // Table-driven directed jobs.
      for (int i = 0; i < 4; i++) begin
         do_job(vecs[i].hdr, vecs[i].tgt, vecs[i].start, vecs[i].cnt, 2);
         ed = vecs[i].exp_found ? ref_digest({vecs[i].exp_nonce, vecs[i].hdr}) : '0;
         check_common($sformatf("vec%0d", i), vecs[i].hdr, vecs[i].start, vecs[i].exp_launch);
         check_result($sformatf("vec%0d", i), vecs[i].exp_found, vecs[i].exp_nonce, ed);
         $display("vec %0d: start=%h count=%0d found=%0b nonce=%h launches=%0d",
                  i, vecs[i].start, vecs[i].cnt, got_found, got_nonce, starts_q.size());
      end

      // Randomised jobs against the search model.
      for (int i = 0; i < 10; i++) begin
         for (int k = 0; k < 6; k++) h[32*k +: 32] = $urandom;
         for (int k = 0; k < 8; k++) t[32*k +: 32] = $urandom;
         t[255:248] = 8'($urandom_range(0, 64));
         st  = (i % 3 == 0) ? 64'hFFFF_FFFF_FFFF_FFFD : {$urandom, $urandom};
         cnt = 64'($urandom_range(1, 6));
         model(h, t, st, cnt, ef, en, ed, el);
         do_job(h, t, st, cnt, $urandom_range(1, 4));
         check_common($sformatf("rnd%0d", i), h, st, el);
         check_result($sformatf("rnd%0d", i), ef, en, ed);
         $display("rnd %0d: start=%h count=%0d found=%0b nonce=%h launches=%0d",
                  i, st, cnt, got_found, got_nonce, starts_q.size());
      end

      // Stale ready from the previous job must be blanked; digest is the fresh one.
      h = 192'hABCD_0000_1234_0000_5678_0000_9ABC_0000_DEF0_0000_1357_0000;
      do_job(h, '1, 64'd42, 64'd3, 3);
      check_common("stale", h, 64'd42, 1);
      check_result("stale", 1'b1, 64'd42, ref_digest({64'd42, h}));
      $display("stale: found=%0b nonce=%h", got_found, got_nonce);

      // Abort in DONE is ignored; ack releases it.
      drive_job(h, '1, 64'd9, 64'd0);
      abort = 1'b1;
      repeat (2) @(negedge clk);
      abort = 1'b0;
      chk("done_abort_valid", 256'(res_valid), 256'(1));
      chk("done_abort_nonce", 256'(res_nonce), 256'(9));
      chk("done_abort_ready", 256'(job_ready), 256'(0));
      res_ack = 1'b1;
      @(negedge clk);
      res_ack = 1'b0;
      chk("done_ack_valid", 256'(res_valid), 256'(0));
      $display("done_abort: nonce=%h", res_nonce);

      // Digest never completes: timeout, then a new job clears the error.
      stub_dead = 1'b1;
      stub_lat = 2;
      drive_job(h, '0, 64'd500, 64'd4);
      wait_start(s);
      g = 0;
      e = -1;
      while (g < 200 && e < 0) begin
         @(negedge clk);
         g++;
         if (err_timeout) e = ncyc;
      end
      chk("timeout_cycles", 256'(e - s), 256'(TO + 1));
      chk("timeout_ready", 256'(job_ready), 256'(1));
      chk("timeout_res_valid", 256'(res_valid), 256'(0));
      $display("timeout: err at +%0d cycles", e - s);
      stub_dead = 1'b0;
      do_job(h, '0, 64'd600, 64'd2, 2);
      chk("timeout_cleared", 256'(err_timeout), 256'(0));
      check_common("after_to", h, 64'd600, 2);
      check_result("after_to", 1'b0, 64'd602, '0);
      $display("after_timeout: found=%0b nonce=%h", got_found, got_nonce);

      // Abort in WAIT: back to IDLE, no result, in-flight digest ignored.
      stub_lat = 15;
      drive_job(h, '0, 64'd700, 64'd5);
      wait_start(s);
      repeat (2) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_ready", 256'(job_ready), 256'(1));
      n0 = starts_q.size();
      saw_valid = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (res_valid) saw_valid = 1'b1;
      end
      chk("abort_no_result", 256'(saw_valid), 256'(0));
      chk("abort_no_relaunch", 256'(starts_q.size()), 256'(n0));
      $display("abort: launches=%0d", starts_q.size());

      // Reset during WAIT of a second job.
      drive_job(h, '0, 64'd800, 64'd5);
      wait_start(s);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_reset_outputs("mid_rst");
      $display("mid_rst: job_ready=%0b res_valid=%0b", job_ready, res_valid);

      // Recovery after reset.
      do_job(h, '0, 64'd900, 64'd2, 1);
      check_common("post_rst", h, 64'd900, 2);
      check_result("post_rst", 1'b0, 64'd902, '0);
      $display("post_rst: found=%0b nonce=%h", got_found, got_nonce);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global watchdog.
   initial begin
      #2000000;
      $display("FAIL watchdog act=running exp=finished");
      $fatal(1, "watchdog");
   end

endmodule
